// File: rtl/apb_cpu_master.sv
// apb_cpu_master: single-transfer APB initiator driven by a host valid/ready command port.
// Rev 1.0 - initial release.
`default_nettype none

module apb_cpu_master #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20,
  parameter int Timeout_Cycles  = 16
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [Amba_Addr_Depth:0]   cmd_addr,
  input  logic [Amba_Word-1:0]       cmd_wdata,

  output logic                       rsp_valid,
  output logic [Amba_Word-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,

  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [Amba_Addr_Depth:0]   PADDR,
  output logic [Amba_Word-1:0]       PWDATA,
  input  logic [Amba_Word-1:0]       PRDATA,
  input  logic                       PREADY
);

  localparam bit         c_TO_EN   = (Timeout_Cycles != 0);
  localparam logic [7:0] c_TO_LAST = 8'(Timeout_Cycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;

  logic w_done;
  logic w_hs;
  logic w_abort;

  // The completion cycle doubles as an accept slot so back-to-back commands skip IDLE.
  assign w_done    = (r_state == ST_ACCESS) && PREADY;
  assign cmd_ready = (r_state == ST_IDLE) || w_done;
  assign w_hs      = cmd_valid && cmd_ready;
  assign w_abort   = c_TO_EN && (r_state == ST_ACCESS) && !PREADY && (r_cnt == c_TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;

      if (w_hs) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end

      case (r_state)
        ST_IDLE: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          busy    <= 1'b0;
          if (w_hs) begin
            r_state <= ST_SETUP;
            PSEL    <= 1'b1;
            busy    <= 1'b1;
          end
        end

        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_cnt   <= 8'd0;
          PSEL    <= 1'b1;
          PENABLE <= 1'b1;
          busy    <= 1'b1;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            rsp_valid <= 1'b1;
            if (!PWRITE) begin
              rsp_rdata <= PRDATA;
            end
            PENABLE <= 1'b0;
            if (w_hs) begin
              r_state <= ST_SETUP;
              PSEL    <= 1'b1;
              busy    <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              PSEL    <= 1'b0;
              busy    <= 1'b0;
            end
          end else if (w_abort) begin
            r_state   <= ST_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_cpu_master.sv
// tb_apb_cpu_master: scoreboard bench for apb_cpu_master with a wait-state capable APB slave model.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module tb_apb_cpu_master;

  localparam int DW = 16;
  localparam int AD = 20;
  localparam int AW = AD + 1;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  always #5 clk = ~clk;

  apb_cpu_master #(
    .Amba_Word(DW),
    .Amba_Addr_Depth(AD),
    .Timeout_Cycles(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  function automatic logic [DW-1:0] init_val(int i);
    return 16'hA5C3 ^ 16'(i ^ 10);
  endfunction

  // APB slave: 32-word memory, PREADY rises after ws_target wait cycles in ACCESS.
  logic [DW-1:0] smem [0:31];
  int            ws_target = 0;
  int            ws_cnt;

  assign PREADY = (ws_cnt >= ws_target);
  assign PRDATA = smem[PADDR[4:0]];

  always @(posedge clk or negedge rst) begin
    if (!rst)                          ws_cnt <= 0;
    else if (PSEL && PENABLE && !PREADY) ws_cnt <= ws_cnt + 1;
    else                               ws_cnt <= 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) smem[i] <= init_val(i);
    end else if (PSEL && PENABLE && PREADY && PWRITE) begin
      smem[PADDR[4:0]] <= PWDATA;
    end
  end

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [0:31];
  logic [DW-1:0] exp_rdata;
  int            total = 0;
  int            bad = 0;
  int            rsp_cnt = 0;
  int            en_cycles = 0;
  int            psel_run = 0;
  int            psel_max = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    exp_rdata = '0;
    sb.delete();
  endtask

  // Monitor: activity counters plus scoreboard compare on every response pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (PSEL) psel_run++;
      else      psel_run = 0;
      if (psel_run > psel_max) psel_max = psel_run;
      if (PSEL && PENABLE) en_cycles++;
      if (rst && rsp_valid) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check_eq("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit err);
    int n;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 100);
    if (!cmd_ready) begin
      check_eq("handshake_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    if (!err) begin
      if (w) ref_mem[a[4:0]] = d;
      else   exp_rdata = ref_mem[a[4:0]];
    end
    sb.push_back('{err: err, rdata: exp_rdata});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_empty", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  int en0;
  int rsp0;
  int n;

  initial begin
    model_reset();

    // Reset state
    @(negedge clk);
    check_eq("rst_psel", {31'd0, PSEL}, 32'd0);
    check_eq("rst_penable", {31'd0, PENABLE}, 32'd0);
    check_eq("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    check_eq("rst_paddr", {11'd0, PADDR}, 32'd0);
    check_eq("rst_pwdata", {16'd0, PWDATA}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single write, no wait states: cycle-by-cycle phase check
    send(1'b1, 21'h00003, 16'h0010, 1'b0);
    @(negedge clk);
    check_eq("wr_setup_psel", {31'd0, PSEL}, 32'd1);
    check_eq("wr_setup_penable", {31'd0, PENABLE}, 32'd0);
    check_eq("wr_setup_busy", {31'd0, busy}, 32'd1);
    check_eq("wr_setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check_eq("wr_acc_penable", {31'd0, PENABLE}, 32'd1);
    check_eq("wr_acc_pwrite", {31'd0, PWRITE}, 32'd1);
    check_eq("wr_acc_paddr", {11'd0, PADDR}, 32'h00003);
    check_eq("wr_acc_pwdata", {16'd0, PWDATA}, 32'h0010);
    @(negedge clk);
    check_eq("wr_done_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("wr_done_psel", {31'd0, PSEL}, 32'd0);
    check_eq("wr_done_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Single read
    send(1'b0, 21'h0000A, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("rd_setup_pwrite", {31'd0, PWRITE}, 32'd0);
    @(negedge clk);
    check_eq("rd_acc_pwrite", {31'd0, PWRITE}, 32'd0);
    check_eq("rd_acc_penable", {31'd0, PENABLE}, 32'd1);
    drain();
    check_eq("rd_value", {16'd0, rsp_rdata}, 32'h0000A5C3);

    // Back-to-back constant load
    psel_max = 0;
    en0  = en_cycles;
    rsp0 = rsp_cnt;
    for (int i = 1; i <= 9; i++) send(1'b1, AW'(i), 16'h0100 + 16'(i), 1'b0);
    drain();
    check_eq("b2b_psel_run", psel_max, 32'd18);
    check_eq("b2b_access_cycles", en_cycles - en0, 32'd9);
    check_eq("b2b_rsp_count", rsp_cnt - rsp0, 32'd9);
    send(1'b0, 21'h00005, 16'h0000, 1'b0);
    drain();

    // Three wait states
    ws_target = 3;
    en0  = en_cycles;
    rsp0 = rsp_cnt;
    send(1'b1, 21'h0000B, 16'h1234, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("ws_penable", {31'd0, PENABLE}, 32'd1);
      check_eq("ws_paddr", {11'd0, PADDR}, 32'h0000B);
      check_eq("ws_pwdata", {16'd0, PWDATA}, 32'h1234);
    end
    @(negedge clk);
    check_eq("ws_done_psel", {31'd0, PSEL}, 32'd0);
    check_eq("ws_done_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    check_eq("ws_access_cycles", en_cycles - en0, 32'd4);
    check_eq("ws_rsp_count", rsp_cnt - rsp0, 32'd1);
    ws_target = 0;
    send(1'b0, 21'h0000B, 16'h0000, 1'b0);
    drain();

    // Timeout abort, then a normal read of the same (unwritten) location
    ws_target = 1000;
    en0 = en_cycles;
    send(1'b1, 21'h0000C, 16'hBEEF, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 60);
    check_eq("to_busy_clear", {31'd0, busy}, 32'd0);
    drain();
    check_eq("to_access_cycles", en_cycles - en0, 32'd16);
    ws_target = 0;
    send(1'b0, 21'h0000C, 16'h0000, 1'b0);
    drain();

    // Asynchronous reset while stalled in ACCESS
    ws_target = 1000;
    send(1'b0, 21'h0000D, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rr_in_access", {31'd0, PENABLE}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("rr_psel_async", {31'd0, PSEL}, 32'd0);
    check_eq("rr_penable_async", {31'd0, PENABLE}, 32'd0);
    model_reset();
    rsp0 = rsp_cnt;
    ws_target = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("rr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rr_busy", {31'd0, busy}, 32'd0);
    check_eq("rr_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("rr_no_rsp", rsp_cnt - rsp0, 32'd0);
    @(posedge clk); #1;

    // Recovery traffic
    send(1'b1, 21'h00007, 16'h5A5A, 1'b0);
    send(1'b0, 21'h00007, 16'h0000, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire

// File: doc/apb_cpu_master.md
Name: apb_cpu_master

Overview:
- APB initiator (CPU side) for the visible watermarking block's APB slave port.
- Takes single read/write commands from a host sequencer or testbench over a valid/ready interface and drives PSEL/PENABLE/PWRITE/PADDR/PWDATA through IDLE, SETUP and ACCESS.
- Returns read data and a per-transfer response.
- Loads calculation constants (0x01..0x09) and pixel data (0x0A+), then polls results.

Parameters:
- Amba_Word, 16: width of PWDATA/PRDATA and the command/response data.
- Amba_Addr_Depth, 20: PADDR is Amba_Addr_Depth+1 bits wide.
- Timeout_Cycles, 16: maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout. Counter is 8 bits, so the legal range is 0..255.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  host command present.
- cmd_ready  output  1  master accepts command this cycle.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  Amba_Addr_Depth+1  target address.
- cmd_wdata  input  Amba_Word  write data.
- rsp_valid  output  1  one-cycle pulse when a transfer ends.
- rsp_rdata  output  Amba_Word  read data; holds last value.
- rsp_err  output  1  valid with rsp_valid; 1 = timeout abort.
- busy  output  1  transfer in SETUP or ACCESS.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  Amba_Addr_Depth+1  APB address.
- PWDATA  output  Amba_Word  APB write data.
- PRDATA  input  Amba_Word  APB read data.
- PREADY  input  1  slave ready; tie to 1 for slaves without wait states.

Behaviour:
- Reset (rst low, async): state=IDLE. PSEL, PENABLE, PWRITE, rsp_valid, rsp_err and busy are 0. PADDR, PWDATA and rsp_rdata are all zero. Timeout counter is 0.
- All outputs are registered. cmd_ready is combinational: high when state==IDLE, or when state==ACCESS && PREADY (completion cycle).
- Command handshake is cmd_valid && cmd_ready. On handshake, cmd_write/addr/wdata are latched into PWRITE/PADDR/PWDATA and the next state is SETUP.
- IDLE: PSEL=0, PENABLE=0. On handshake go to SETUP. Otherwise stay; PADDR/PWDATA/PWRITE hold their last values.
- SETUP (exactly one cycle): PSEL=1, PENABLE=0. Next state ACCESS unconditionally. Counter cleared.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA are stable throughout.
  - If PREADY=1, the transfer completes:
    - rsp_valid=1 next cycle; rsp_err=0.
    - For a read, rsp_rdata<=PRDATA sampled this cycle; for a write, rsp_rdata is unchanged.
    - If a handshake occurs in the same cycle (back-to-back), next state is SETUP with PSEL kept at 1 and PENABLE dropped to 0.
    - Else next state is IDLE with PSEL=0 and PENABLE=0.
  - If PREADY=0: counter increments. If Timeout_Cycles!=0 and the counter reaches Timeout_Cycles-1 while PREADY is still 0, abort: next state IDLE, PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata unchanged.
- Latency with no wait states: 2 cycles from handshake to the completion edge; rsp_valid is asserted 3 cycles after the handshake cycle. Back-to-back sustains 1 transfer per 2 cycles.
- rsp_valid is a single-cycle pulse with no backpressure; the host must sample it.
- busy = (state!=IDLE).
- PREADY and PRDATA are ignored outside ACCESS.
- Reset mid-transfer: PSEL/PENABLE drop immediately (async). The pending command is discarded and no rsp_valid is generated.
- PADDR wraps naturally at Amba_Addr_Depth+1 bits; there is no address arithmetic in this block.

Test Plan:
- Write: cmd addr=0x00003, wdata=0x0010, PREADY=1 -> one SETUP cycle (PSEL=1, PENABLE=0), then one ACCESS cycle (PENABLE=1, PWRITE=1, PADDR=0x00003, PWDATA=0x0010). Next cycle rsp_valid=1, rsp_err=0, PSEL=0.
- Read: cmd read addr=0x0000A, slave drives PRDATA=0xA5C3 in ACCESS -> rsp_valid=1, rsp_rdata=0xA5C3; PWRITE=0 throughout.
- Back-to-back: 9 writes to addr 0x01..0x09 with cmd_valid held high -> PSEL stays 1 for 18 consecutive cycles, PENABLE alternates 0/1, and 9 rsp_valid pulses occur with rsp_err=0.
- Wait states: PREADY low for 3 ACCESS cycles then high -> PENABLE high for 4 cycles with PADDR/PWDATA stable, and a single rsp_valid.
- Timeout: Timeout_Cycles=16, PREADY held 0 -> exactly 16 ACCESS cycles, then PSEL=0 and rsp_valid=1 with rsp_err=1. The next command proceeds normally.
- Reset during ACCESS (PREADY=0): rst low -> PSEL=PENABLE=0 asynchronously, no rsp_valid. After release, cmd_ready=1 and busy=0.
